// File: rtl/bp_be_br_resolve.sv
// Branch resolution stage: registers integer-pipe results, detects next-PC mispredicts,
// flushes and redirects the frontend, and emits attaboys for correct control-flow predictions.
module bp_be_br_resolve #(
    parameter int unsigned vaddr_width_p = 39,
    parameter int unsigned cnt_width_p   = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     ex_v_i,
    input  logic                     ex_poison_i,
    input  logic                     ex_ctrl_v_i,
    input  logic [vaddr_width_p-1:0] ex_pc_i,
    input  logic [vaddr_width_p-1:0] ex_br_tgt_i,
    input  logic [vaddr_width_p-1:0] ex_pred_npc_i,
    input  logic                     issue_v_i,
    input  logic [vaddr_width_p-1:0] issue_pc_i,
    output logic                     flush_o,
    output logic                     stale_o,
    output logic                     fe_cmd_v_o,
    input  logic                     fe_cmd_ready_i,
    output logic [vaddr_width_p-1:0] fe_cmd_npc_o,
    output logic                     attaboy_v_o,
    output logic [vaddr_width_p-1:0] attaboy_pc_o,
    input  logic                     cnt_clr_i,
    output logic [cnt_width_p-1:0]   mispredict_cnt_o
);

    typedef enum logic [1:0] {StIdle, StRedirect, StWaitFetch} state_e;

    state_e                   state_q, state_d;
    logic                     v_q, ctrl_q;
    logic [vaddr_width_p-1:0] pc_q, tgt_q, pred_q;
    logic [vaddr_width_p-1:0] npc_q, npc_d;
    logic [cnt_width_p-1:0]   cnt_q, cnt_d;
    logic                     mispredict, capture;

    localparam logic [cnt_width_p-1:0] CntOne = {{(cnt_width_p-1){1'b0}}, 1'b1};

    assign mispredict = v_q & (tgt_q != pred_q);
    // A mispredicting result blocks capture so the same-cycle younger instruction is dropped.
    assign capture    = ex_v_i & ~ex_poison_i & (state_q == StIdle) & ~mispredict;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q    <= 1'b0;
            ctrl_q <= 1'b0;
            pc_q   <= '0;
            tgt_q  <= '0;
            pred_q <= '0;
        end else begin
            v_q <= capture;
            if (capture) begin
                ctrl_q <= ex_ctrl_v_i;
                pc_q   <= ex_pc_i;
                tgt_q  <= ex_br_tgt_i;
                pred_q <= ex_pred_npc_i;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        npc_d      = npc_q;
        flush_o    = 1'b0;
        stale_o    = 1'b0;
        fe_cmd_v_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mispredict) begin
                    flush_o = 1'b1;
                    npc_d   = tgt_q;
                    state_d = StRedirect;
                end
            end
            StRedirect: begin
                fe_cmd_v_o = 1'b1;
                stale_o    = issue_v_i;
                if (fe_cmd_ready_i) begin
                    state_d = StWaitFetch;
                end
            end
            StWaitFetch: begin
                if (issue_v_i) begin
                    if (issue_pc_i == npc_q) begin
                        state_d = StIdle;
                    end else begin
                        stale_o = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (mispredict) begin
            if (cnt_clr_i) begin
                cnt_d = CntOne;
            end else if (!(&cnt_q)) begin
                cnt_d = cnt_q + CntOne;
            end
        end else if (cnt_clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            npc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            npc_q   <= npc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fe_cmd_npc_o     = fe_cmd_v_o ? npc_q : '0;
    assign attaboy_v_o      = v_q & ctrl_q & ~mispredict;
    assign attaboy_pc_o     = attaboy_v_o ? pc_q : '0;
    assign mispredict_cnt_o = cnt_q;

endmodule
